// File: rtl/numbotron_pkg.sv
// ============================================================================
// Module   : numbotron_pkg
// Purpose  : Shared types, constants and BCD helper for the numbotron blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package numbotron_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_CMP   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } numload_state_t;

  localparam int         NUM_DIGITS        = 3;
  localparam logic [3:0] BCD_MAX           = 4'd9;
  localparam logic [3:0] NUMLOAD_MAX_STEPS = 4'd10;

  function automatic logic bcd_valid(input logic [11:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_sel.sv
// ============================================================================
// Module   : bcd_digit_sel
// Purpose  : Picks digit i_sel from read-back and target and flags equality.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_sel (
  input  logic [1:0]  i_sel,
  input  logic [11:0] i_reg_val,
  input  logic [11:0] i_tgt,
  output logic        o_match
);

  logic [3:0] w_reg_digit;
  logic [3:0] w_tgt_digit;

  always_comb begin
    w_reg_digit = 4'd0;
    w_tgt_digit = 4'd0;
    case (i_sel)
      2'd0: begin
        w_reg_digit = i_reg_val[3:0];
        w_tgt_digit = i_tgt[3:0];
      end
      2'd1: begin
        w_reg_digit = i_reg_val[7:4];
        w_tgt_digit = i_tgt[7:4];
      end
      2'd2: begin
        w_reg_digit = i_reg_val[11:8];
        w_tgt_digit = i_tgt[11:8];
      end
      default: begin
        w_reg_digit = 4'd0;
        w_tgt_digit = 4'd0;
      end
    endcase
  end

  assign o_match = (w_reg_digit == w_tgt_digit);

endmodule

`default_nettype wire

// File: rtl/numreg_loader.sv
// ============================================================================
// Module   : numreg_loader
// Purpose  : Clears a 3-digit BCD register then steps each digit up to target.
//            Optional NUMLOAD_VERIFY_EN adds a stuck-digit step limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module numreg_loader
  import numbotron_pkg::*;
#(
  parameter int NUM_DIGITS = numbotron_pkg::NUM_DIGITS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] target,
  input  logic [11:0] reg_val,
  output logic [2:0]  reg_reset,
  output logic [2:0]  reg_inc_dig,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [1:0] C_LAST_DIGIT = 2'(NUM_DIGITS - 1);

  numload_state_t r_state, w_state_nxt;
  logic [1:0]     r_d, w_d_nxt;
  logic [11:0]    r_tgt_q, w_tgt_nxt;
  logic           r_error, w_error_nxt;
  logic           w_match;
`ifdef NUMLOAD_VERIFY_EN
  logic [3:0]     r_steps, w_steps_nxt;
`endif

  bcd_digit_sel u_digit_sel (
    .i_sel     (r_d),
    .i_reg_val (reg_val),
    .i_tgt     (r_tgt_q),
    .o_match   (w_match)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_d     <= 2'd0;
      r_tgt_q <= 12'd0;
      r_error <= 1'b0;
`ifdef NUMLOAD_VERIFY_EN
      r_steps <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_tgt_q <= w_tgt_nxt;
      r_error <= w_error_nxt;
`ifdef NUMLOAD_VERIFY_EN
      r_steps <= w_steps_nxt;
`endif
    end
  end

  // Register-facing outputs decode straight from state so reset clears them at once.
  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_tgt_nxt   = r_tgt_q;
    w_error_nxt = 1'b0;
    reg_reset   = 3'b000;
    reg_inc_dig = 3'b000;
    done        = 1'b0;
`ifdef NUMLOAD_VERIFY_EN
    w_steps_nxt = r_steps;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (bcd_valid(target)) begin
            w_tgt_nxt   = target;
            w_d_nxt     = 2'd0;
            w_state_nxt = S_CLEAR;
`ifdef NUMLOAD_VERIFY_EN
            w_steps_nxt = 4'd0;
`endif
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        reg_reset   = 3'b111;
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        if (!w_match) begin
`ifdef NUMLOAD_VERIFY_EN
          if (r_steps == NUMLOAD_MAX_STEPS) begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            reg_inc_dig = 3'b001 << r_d;
            w_steps_nxt = r_steps + 4'd1;
            w_state_nxt = S_WAIT;
          end
`else
          reg_inc_dig = 3'b001 << r_d;
          w_state_nxt = S_WAIT;
`endif
        end else if (r_d == C_LAST_DIGIT) begin
          w_state_nxt = S_DONE;
        end else begin
          w_d_nxt = r_d + 2'd1;
`ifdef NUMLOAD_VERIFY_EN
          w_steps_nxt = 4'd0;
`endif
        end
      end
      S_WAIT: begin
        w_state_nxt = S_CMP;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_numreg_loader.sv
// ============================================================================
// Module   : tb_numreg_loader
// Purpose  : Self-checking bench for numreg_loader with a BCD register model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_numreg_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] target = 12'd0;
  logic [11:0] reg_val;
  logic [2:0]  reg_reset;
  logic [2:0]  reg_inc_dig;
  logic        busy, done, error;

  logic [11:0] m_reg = 12'h777;
  bit          stuck0 = 1'b0;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  numreg_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .target      (target),
    .reg_val     (reg_val),
    .reg_reset   (reg_reset),
    .reg_inc_dig (reg_inc_dig),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // NUMReg stand-in: per-digit clear or increment, no carry between digits.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reg_reset[i]) m_reg[4*i +: 4] <= 4'd0;
      else if (reg_inc_dig[i] && !(stuck0 && i == 0))
        m_reg[4*i +: 4] <= (m_reg[4*i +: 4] == 4'd9) ? 4'd0 : m_reg[4*i +: 4] + 4'd1;
    end
  end
  assign reg_val = m_reg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rand_bcd();
    return {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
  endfunction

  function automatic int digit_sum(input logic [11:0] t);
    return int'(t[3:0]) + int'(t[7:4]) + int'(t[11:8]);
  endfunction

  // Called #1 after a rising edge with start low; returns with the same alignment.
  task automatic run_load(input logic [11:0] tgt, input bit chaff);
    int cyc, done_cyc, rst_cnt, rst_cyc, viol, busy_bad, errs;
    int inc_cnt[3];
    int last_inc[3];
    cyc = 1; done_cyc = -1; rst_cnt = 0; rst_cyc = -1; viol = 0; busy_bad = 0; errs = 0;
    for (int i = 0; i < 3; i++) begin inc_cnt[i] = 0; last_inc[i] = -10; end
    start = 1'b1; target = tgt;
    @(posedge clk); #1;
    start = 1'b0; target = 12'($urandom);
    while (cyc <= 80 && done_cyc < 0) begin
      if (reg_reset != 3'b000) begin
        rst_cnt++; rst_cyc = cyc;
        if (reg_reset != 3'b111) viol++;
      end
      if ($countones(reg_inc_dig) > 1) viol++;
      if (reg_reset != 3'b000 && reg_inc_dig != 3'b000) viol++;
      for (int i = 0; i < 3; i++) begin
        if (reg_inc_dig[i]) begin
          if (cyc - last_inc[i] < 2) viol++;
          last_inc[i] = cyc;
          inc_cnt[i]++;
        end
      end
      if (error) errs++;
      if (busy !== 1'b1) busy_bad++;
      if (done) done_cyc = cyc;
      else begin
        if (chaff) begin start = 1'($urandom); target = 12'($urandom); end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check_eq("done_cycle", done_cyc, 5 + 2 * digit_sum(tgt));
    check_eq("reset_pulses", rst_cnt, 1);
    check_eq("reset_cycle", rst_cyc, 1);
    for (int i = 0; i < 3; i++) check_eq("inc_pulses", inc_cnt[i], int'(tgt[4*i +: 4]));
    check_eq("protocol_viol", viol, 0);
    check_eq("busy_low_in_load", busy_bad, 0);
    check_eq("error_in_load", errs, 0);
    check_eq("final_reg_val", reg_val, tgt);
    @(posedge clk); #1;
    check_eq("idle_after_done", {busy, done, error}, 3'b000);
  endtask

  task automatic run_invalid(input logic [11:0] bad);
    logic [11:0] saved;
    saved = m_reg;
    start = 1'b1; target = bad;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("reject_error", error, 1'b1);
    check_eq("reject_quiet", {busy, done, reg_reset, reg_inc_dig}, 8'd0);
    @(posedge clk); #1;
    check_eq("reject_error_1cyc", {error, busy}, 2'b00);
    check_eq("reject_reg_kept", reg_val, saved);
  endtask

  initial begin
    logic [11:0] t;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {busy, done, error, reg_reset, reg_inc_dig}, 9'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_after_reset", {busy, done, error}, 3'b000);

    run_load(12'h123, 1'b0);
    run_load(12'h000, 1'b0);
    run_load(12'h999, 1'b1);
    for (int k = 0; k < 6; k++) run_load(rand_bcd(), 1'b1);

    // Busy-time start with another target must not disturb the first load.
    start = 1'b1; target = 12'h042;
    @(posedge clk); #1;
    target = 12'h987;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("ignored_start_val", reg_val, 12'h042);
    check_eq("ignored_start_idle", busy, 1'b0);

    run_invalid(12'h0A5);
    do t = 12'($urandom); while (t[3:0] <= 9 && t[7:4] <= 9 && t[11:8] <= 9);
    run_invalid(t);

    // Reset in cycle 6 of a 999 load: units has taken pulses from cycles 2 and 4.
    start = 1'b1; target = 12'h999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midreset_outputs", {busy, done, error, reg_reset, reg_inc_dig}, 9'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("midreset_idle", {busy, done, error}, 3'b000);
    check_eq("midreset_partial", reg_val, 12'h002);
    run_load(12'h314, 1'b1);

`ifdef NUMLOAD_VERIFY_EN
    begin
      int pulses, err_seen, done_seen;
      pulses = 0; err_seen = 0; done_seen = 0;
      stuck0 = 1'b1;
      start = 1'b1; target = 12'h003;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (reg_inc_dig[0]) pulses++;
        if (error) err_seen++;
        if (done) done_seen++;
        @(posedge clk); #1;
      end
      stuck0 = 1'b0;
      check_eq("verify_pulses", pulses, 10);
      check_eq("verify_error", err_seen, 1);
      check_eq("verify_no_done", done_seen, 0);
      check_eq("verify_idle", busy, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
